// File: rtl/cic_uart_pkg.sv
// Shared types and constants for the CIC sample UART serializer.
package cic_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int FRAME_DATA_BITS = 8;
    localparam int DEF_FIFO_DEPTH  = 4;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LEVEL_W = level_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/cic_sample_fifo.sv
// Circular sample buffer with occupancy count and sticky overflow flag.
module cic_sample_fifo
    import cic_uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = FRAME_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int LVL_W = level_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LVL_W'(DEPTH));
    assign empty   = (cnt == '0);
    // A pop frees the slot this cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + LVL_W'(do_push) - LVL_W'(do_pop);
            if (push & ~do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_uart_serializer.sv
// Buffers CIC decimated samples and sends each as a UART frame on tx_o.
// Define CIC_UART_PARITY_EN for 8E1 framing instead of 8N1.
module cic_uart_serializer
    import cic_uart_pkg::*;
#(
    parameter int SAMPLE_W   = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 16,
    parameter int CTR_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ds_clk_i,
    input  logic [SAMPLE_W-1:0]         sample_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int DW = FRAME_DATA_BITS;

    tx_state_e     state, state_n;
    logic [CTR_W-1:0] baud_ctr, baud_ctr_n;
    logic [2:0]    bit_ctr, bit_ctr_n;
    logic [DW-1:0] shift, shift_n;
    logic          tx_q, tx_n;
    logic          ds_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [DW-1:0] fifo_dout;
    logic          bit_end;
`ifdef CIC_UART_PARITY_EN
    logic          par_q, par_n;
`endif

    assign push = ds_clk_i & ~ds_q;

    cic_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (DW'(sample_i)),
        .pop      (pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o),
        .overflow (overflow_o)
    );

    assign bit_end = (baud_ctr == CTR_W'(BAUD_DIV - 1));
    assign tx_o    = tx_q;
    assign busy_o  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds_q     <= 1'b0;
            state    <= ST_IDLE;
            baud_ctr <= '0;
            bit_ctr  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
`ifdef CIC_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            ds_q     <= ds_clk_i;
            state    <= state_n;
            baud_ctr <= baud_ctr_n;
            bit_ctr  <= bit_ctr_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
`ifdef CIC_UART_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    // tx_n is the level for the next cycle, so tx_o is a clean register.
    always_comb begin
        state_n    = state;
        baud_ctr_n = bit_end ? '0 : baud_ctr + CTR_W'(1);
        bit_ctr_n  = bit_ctr;
        shift_n    = shift;
        tx_n       = 1'b1;
        pop        = 1'b0;
`ifdef CIC_UART_PARITY_EN
        par_n      = par_q;
`endif
        unique case (state)
            ST_IDLE: begin
                baud_ctr_n = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_dout;
                    bit_ctr_n = '0;
                    state_n   = ST_START;
                    tx_n      = 1'b0;
`ifdef CIC_UART_PARITY_EN
                    par_n     = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    state_n = ST_DATA;
                    tx_n    = shift[0];
                end
            end
            ST_DATA: begin
                tx_n = shift[0];
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_ctr_n = bit_ctr + 3'd1;
                    tx_n      = shift[1];
                    if (bit_ctr == 3'd7) begin
`ifdef CIC_UART_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = par_q;
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end
                end
            end
`ifdef CIC_UART_PARITY_EN
            ST_PARITY: begin
                tx_n = par_q;
                if (bit_end) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
